mem_bridge: RTL and testbench
=============================

MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1, giving the extra RAM access cycles per transaction (legal range 0..7).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port mem_cmd, input, 2 bits: CPU command; 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 treated as NONE.
REQ-005 The block SHALL have port mem_addr, input, 9 bits: CPU address.
REQ-006 The block SHALL have port write_data, input, 16 bits: CPU store data.
REQ-007 The block SHALL have port read_data, output, 16 bits: registered load data returned to the CPU.
REQ-008 The block SHALL have port mem_ready, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have ports ram_addr (output, 8 bits), ram_wdata (output, 16 bits), ram_we (output, 1 bit) and ram_rdata (input, 16 bits): a synchronous single-port RAM with 1-cycle read latency.
REQ-010 The block SHALL have port SW, input, 8 bits: asynchronous slide switches.
REQ-011 The block SHALL have port LEDR, output, 8 bits: LED register.
REQ-012 The block SHALL have port bad_addr, output, 1 bit: sticky unmapped-access flag.

Function
REQ-013 Address map SHALL be: mem_addr[8]==0 selects RAM (ram_addr = mem_addr[7:0]); 9'h100 selects LEDR (write-only); 9'h140 selects the switches (read-only); everything else is unmapped.
REQ-014 FSM SHALL have states IDLE, ACCESS and DONE.
REQ-015 In IDLE, a READ or WRITE on mem_cmd SHALL be captured at the clock edge (command, address and data latched) with a move to ACCESS and the wait counter loaded with WAIT_STATES; NONE keeps IDLE.
REQ-016 ACCESS SHALL drive ram_addr and ram_wdata from the latched values and decrement the counter each cycle; when the counter is 0, the next edge SHALL move to DONE.
REQ-017 ram_we SHALL be high only during the first ACCESS cycle of a WRITE to RAM; it SHALL be 0 in all other cycles.
REQ-018 A WRITE to 9'h100 SHALL load LEDR with write_data[7:0] at the end of the first ACCESS cycle.
REQ-019 On the ACCESS-to-DONE edge, read_data SHALL load as follows: ram_rdata for a RAM read; {8'h00, synchronized SW} for 9'h140; 16'h0000 for an unmapped read. read_data SHALL hold its value through WRITEs and until the next READ completes.
REQ-020 DONE SHALL last exactly one cycle with mem_ready=1, then return to IDLE unconditionally; mem_cmd SHALL be ignored in DONE and ACCESS.
REQ-021 Latency SHALL be: command sampled at edge E0, mem_ready high in the cycle after edge E0+WAIT_STATES+1 (WAIT_STATES=0: mem_ready high after E1).
REQ-022 The CPU SHALL drop mem_cmd to NONE in the mem_ready cycle; a command still present in IDLE afterwards SHALL start a new transaction (back-to-back, no bubble beyond DONE).
REQ-023 SW SHALL pass through a two-flop synchronizer before use; sampled switch data is therefore at least 2 cycles old.
REQ-024 bad_addr SHALL be set on the ACCESS-to-DONE edge of any unmapped access, of a WRITE to 9'h140, or of a READ of 9'h100; it SHALL clear only on reset. An unmapped WRITE SHALL change no state other than bad_addr.

Reset
REQ-025 With reset low (asynchronous, at any time, including mid-ACCESS), the block SHALL set FSM=IDLE, counter=0, read_data=16'h0000, mem_ready=0, ram_we=0, LEDR=8'h00, bad_addr=0 and the synchronizer flops to 0.
REQ-026 A transaction interrupted by reset SHALL be abandoned: no mem_ready pulse, and no RAM write if reset falls before the ram_we cycle edge.
REQ-027 After reset rises, the first edge SHALL be able to sample a new command.

Verification
REQ-028 WAIT_STATES=1: WRITE 16'hBEEF to 9'h005, then READ 9'h005 -> one ram_we pulse at address 8'h05; second mem_ready 3 cycles after the READ sample; read_data=16'hBEEF.
REQ-029 WRITE 16'h12A5 to 9'h100 -> LEDR=8'hA5 and no ram_we; READ 9'h140 with SW=8'h3C held for 3 cycles -> read_data=16'h003C.
REQ-030 READ 9'h1FF -> read_data=16'h0000 and bad_addr=1, which stays 1 through subsequent legal accesses until reset.
REQ-031 WAIT_STATES=0: mem_cmd held at READ continuously -> mem_ready pulses every 3 cycles, each pulse exactly 1 cycle wide.
REQ-032 Reset asserted during ACCESS of a READ -> all outputs go to reset values immediately (before the next edge); no mem_ready pulse; the next command completes normally.

Source files
------------

// File: rtl/mem_bridge_if.sv
// CPU-side request/response bus of the memory bridge.
// The CPU drives the command and samples the registered load data and ready pulse.
interface mem_bridge_if;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;

  modport master (output mem_cmd, mem_addr, write_data, input read_data, mem_ready);
  modport slave  (input mem_cmd, mem_addr, write_data, output read_data, mem_ready);
endinterface

// File: rtl/mem_bridge.sv
// CPU-to-RAM/MMIO bridge: IDLE/ACCESS/DONE sequencer with programmable wait states,
// an LED register, synchronized switch input and a sticky unmapped-access flag.
module mem_bridge #(
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_bridge_if.slave      cpu,
  output logic [7:0]       ram_addr,
  output logic [15:0]      ram_wdata,
  output logic             ram_we,
  input  logic [15:0]      ram_rdata,
  input  logic [7:0]       SW,
  output logic [7:0]       LEDR,
  output logic             bad_addr
);
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic        first_q;
  logic        wr_q;
  logic [8:0]  addr_q;
  logic [15:0] data_q;
  logic [15:0] rdata_q;
  logic [7:0]  sw_meta, sw_sync;

  logic start, is_ram, is_led, is_sw, unmapped;

  assign start    = (cpu.mem_cmd == CMD_READ) || (cpu.mem_cmd == CMD_WRITE);
  assign is_ram   = ~addr_q[8];
  assign is_led   = (addr_q == 9'h100);
  assign is_sw    = (addr_q == 9'h140);
  assign unmapped = ~is_ram & ~is_led & ~is_sw;

  // In IDLE the RAM address follows the CPU bus so the 1-cycle read data is
  // already valid in the first ACCESS cycle, even with zero wait states.
  assign ram_addr  = (state_q == IDLE) ? cpu.mem_addr[7:0] : addr_q[7:0];
  assign ram_wdata = data_q;
  assign ram_we    = (state_q == ACCESS) && first_q && wr_q && is_ram;

  assign cpu.mem_ready = (state_q == DONE);
  assign cpu.read_data = rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCESS;
      ACCESS:  if (cnt_q == 3'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= 3'd0;
      first_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 9'h000;
      data_q   <= 16'h0000;
      rdata_q  <= 16'h0000;
      LEDR     <= 8'h00;
      bad_addr <= 1'b0;
      sw_meta  <= 8'h00;
      sw_sync  <= 8'h00;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
      case (state_q)
        IDLE: if (start) begin
          wr_q    <= (cpu.mem_cmd == CMD_WRITE);
          addr_q  <= cpu.mem_addr;
          data_q  <= cpu.write_data;
          cnt_q   <= 3'(WAIT_STATES);
          first_q <= 1'b1;
        end
        ACCESS: begin
          first_q <= 1'b0;
          if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
          if (first_q && wr_q && is_led) LEDR <= data_q[7:0];
          if (cnt_q == 3'd0) begin
            if (!wr_q)
              rdata_q <= is_ram ? ram_rdata : (is_sw ? {8'h00, sw_sync} : 16'h0000);
            if (unmapped || (wr_q && is_sw) || (!wr_q && is_led))
              bad_addr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: WAIT_STATES=1 instance for function/reset,
// WAIT_STATES=0 instance for back-to-back READ pacing.
module tb_mem_bridge;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] SW = 8'h00;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  mem_bridge_if b1();
  mem_bridge_if b0();

  logic [7:0]  a1, a0, led1, led0;
  logic [15:0] wd1, wd0, rd1, rd0;
  logic        we1, we0, bad1, bad0;
  logic [15:0] mem1 [256];
  logic [15:0] mem0 [256];

  mem_bridge #(.WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset), .cpu(b1.slave),
    .ram_addr(a1), .ram_wdata(wd1), .ram_we(we1), .ram_rdata(rd1),
    .SW(SW), .LEDR(led1), .bad_addr(bad1));

  mem_bridge #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .cpu(b0.slave),
    .ram_addr(a0), .ram_wdata(wd0), .ram_we(we0), .ram_rdata(rd0),
    .SW(SW), .LEDR(led0), .bad_addr(bad0));

  always @(posedge clk) begin
    if (we1) mem1[a1] <= wd1;
    rd1 <= mem1[a1];
    if (we0) mem0[a0] <= wd0;
    rd0 <= mem0[a0];
  end

  int we_cnt = 0;
  logic [7:0] we_addr = 8'h00;
  int rdy_cnt = 0;
  always @(negedge clk) begin
    if (we1) begin we_cnt++; we_addr = a1; end
    if (b1.mem_ready) rdy_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one command on the WAIT_STATES=1 bridge; returns at the mem_ready cycle.
  task automatic xact(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                      output int lat);
    @(negedge clk);
    b1.mem_cmd = c; b1.mem_addr = a; b1.write_data = d;
    @(negedge clk);
    lat = 1;
    b1.mem_cmd = 2'b00;
    while (!b1.mem_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int r0, w0;
    b1.mem_cmd = 2'b00; b1.mem_addr = 9'h000; b1.write_data = 16'h0000;
    b0.mem_cmd = 2'b00; b0.mem_addr = 9'h000; b0.write_data = 16'h0000;

    repeat (3) @(negedge clk);
    check("rst_ready",  {15'h0, b1.mem_ready}, 16'h0000);
    check("rst_rdata",  b1.read_data,          16'h0000);
    check("rst_ledr",   {8'h00, led1},         16'h0000);
    check("rst_bad",    {15'h0, bad1},         16'h0000);
    check("rst_we",     {15'h0, we1},          16'h0000);
    reset = 1'b1;

    xact(2'b10, 9'h005, 16'hBEEF, lat);
    check("wr_ram_lat", 16'(lat), 16'd3);
    xact(2'b01, 9'h005, 16'h0000, lat);
    check("rd_ram_lat", 16'(lat), 16'd3);
    check("rd_ram_data", b1.read_data, 16'hBEEF);
    check("we_pulses",  16'(we_cnt), 16'd1);
    check("we_addr",    {8'h00, we_addr}, 16'h0005);
    check("bad_clean",  {15'h0, bad1}, 16'h0000);

    xact(2'b10, 9'h100, 16'h12A5, lat);
    check("led_val",    {8'h00, led1}, 16'h00A5);
    check("led_no_we",  16'(we_cnt), 16'd1);
    check("rd_hold_wr", b1.read_data, 16'hBEEF);

    SW = 8'h3C;
    repeat (3) @(negedge clk);
    xact(2'b01, 9'h140, 16'h0000, lat);
    check("sw_read",    b1.read_data, 16'h003C);
    check("sw_bad",     {15'h0, bad1}, 16'h0000);

    xact(2'b01, 9'h1FF, 16'h0000, lat);
    check("unmap_rdata", b1.read_data, 16'h0000);
    check("unmap_bad",   {15'h0, bad1}, 16'h0001);

    xact(2'b10, 9'h1A0, 16'hFFFF, lat);
    check("unmap_wr_led", {8'h00, led1}, 16'h00A5);
    check("unmap_wr_we",  16'(we_cnt), 16'd1);
    check("unmap_wr_rd",  b1.read_data, 16'h0000);

    xact(2'b01, 9'h005, 16'h0000, lat);
    check("sticky_rd",  b1.read_data, 16'hBEEF);
    check("sticky_bad", {15'h0, bad1}, 16'h0001);

    xact(2'b10, 9'h140, 16'h0011, lat);
    check("wr_sw_led",  {8'h00, led1}, 16'h00A5);

    // Reset in the middle of a READ's ACCESS phase.
    @(negedge clk);
    b1.mem_cmd = 2'b01; b1.mem_addr = 9'h005;
    @(negedge clk);
    b1.mem_cmd = 2'b00;
    r0 = rdy_cnt; w0 = we_cnt;
    #2 reset = 1'b0;
    #1;
    check("mid_ready", {15'h0, b1.mem_ready}, 16'h0000);
    check("mid_rdata", b1.read_data,          16'h0000);
    check("mid_ledr",  {8'h00, led1},         16'h0000);
    check("mid_bad",   {15'h0, bad1},         16'h0000);
    check("mid_we",    {15'h0, we1},          16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_no_pulse", 16'(rdy_cnt - r0), 16'd0);
    check("mid_no_write", 16'(we_cnt - w0), 16'd0);
    xact(2'b01, 9'h005, 16'h0000, lat);
    check("post_rst_lat", 16'(lat), 16'd3);
    check("post_rst_rd",  b1.read_data, 16'hBEEF);

    // Zero wait states, READ held continuously: one-cycle pulse every 3 cycles.
    repeat (3) @(negedge clk);
    @(negedge clk);
    b0.mem_cmd = 2'b01; b0.mem_addr = 9'h140;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("ws0_ready_%0d", k), {15'h0, b0.mem_ready}, (k % 3 == 2) ? 16'd1 : 16'd0);
    end
    b0.mem_cmd = 2'b00;
    check("ws0_rdata", b0.read_data, 16'h003C);
    check("ws0_bad",   {15'h0, bad0}, 16'h0000);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
